// File: rtl/bypass_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bypass_ctrl
//  Purpose  : Operand forwarding and load-use hazard control for the ID stage.
//             Tracks destination info of the EX/MEM/WB stages in a shadow
//             pipeline, drives one-hot bypass selects for rs and rt, and
//             raises a load-use stall toward PC and IF/ID.
//  Revision : 1.0 - initial release
// ============================================================================
module bypass_ctrl #(
  parameter int REG_AW       = 5,
  parameter bit LOAD_MEM_FWD = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  input  logic              hold,
  input  logic              flush,
  output logic [3:0]        sel_rs,
  output logic [3:0]        sel_rt,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  // One-hot bypass mux encodings
  localparam logic [3:0] c_SEL_RF  = 4'b0001;
  localparam logic [3:0] c_SEL_EX  = 4'b0010;
  localparam logic [3:0] c_SEL_MEM = 4'b0100;
  localparam logic [3:0] c_SEL_WB  = 4'b1000;

  // One shadow-pipeline slot: valid, writes-register, destination, is-load
  typedef struct packed {
    logic              v;
    logic              wr;
    logic [REG_AW-1:0] rd;
    logic              ld;
  } entry_t;

  entry_t ex_q, ex_d;
  entry_t mem_q, mem_d;
  entry_t wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic   w_rs_chk;
  logic   w_rt_chk;
  logic   w_rs_ld_hit;
  logic   w_rt_ld_hit;
  logic   w_stall;
  entry_t w_id_entry;

  // A stage entry can supply a value only if it is live and writes that register
  function automatic logic hit(input entry_t e, input logic [REG_AW-1:0] addr);
    return e.v & e.wr & (e.rd == addr);
  endfunction

  // Youngest producer wins; unused operands and r0 always read the register file
  function automatic logic [3:0] pick(input logic chk, input logic [REG_AW-1:0] addr,
                                      input entry_t ex, input entry_t mem, input entry_t wb);
    logic [3:0] s;
    s = c_SEL_RF;
    if (chk) begin
      if (hit(ex, addr))       s = c_SEL_EX;
      else if (hit(mem, addr)) s = c_SEL_MEM;
      else if (hit(wb, addr))  s = c_SEL_WB;
    end
    return s;
  endfunction

  // A load whose data is not yet forwardable forces the consumer to wait
  function automatic logic ld_hit(input logic chk, input logic [REG_AW-1:0] addr,
                                  input entry_t ex, input entry_t mem);
    logic h;
    h = hit(ex, addr) & ex.ld;
    if (!LOAD_MEM_FWD) h = h | (hit(mem, addr) & mem.ld);
    return chk & h;
  endfunction

  // Operand selects and load-use stall, evaluated in the same cycle as ID
  always_comb begin
    w_rs_chk    = id_rs_used & (id_rs != '0);
    w_rt_chk    = id_rt_used & (id_rt != '0);
    sel_rs      = pick(w_rs_chk, id_rs, ex_q, mem_q, wb_q);
    sel_rt      = pick(w_rt_chk, id_rt, ex_q, mem_q, wb_q);
    w_rs_ld_hit = ld_hit(w_rs_chk, id_rs, ex_q, mem_q);
    w_rt_ld_hit = ld_hit(w_rt_chk, id_rt, ex_q, mem_q);
    // A flushed instruction is dead, so it can never be a load-use consumer
    w_stall     = id_valid & ~flush & (w_rs_ld_hit | w_rt_ld_hit);
    stall       = w_stall;
  end

  // Next shadow state: advance one stage unless frozen; stalled/killed ID becomes a bubble
  always_comb begin
    w_id_entry = '0;
    if (id_valid && !w_stall && !flush) begin
      w_id_entry.v  = 1'b1;
      w_id_entry.wr = id_wr_en;
      w_id_entry.rd = id_rd;
      w_id_entry.ld = id_is_load;
    end
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    stall_cnt_d = stall_cnt_q;
    if (!hold) begin
      ex_d  = w_id_entry;
      mem_d = ex_q;
      wb_d  = mem_q;
      if (w_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Shadow pipeline and stall counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bypass_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bypass_ctrl
//  Purpose  : Directed, table-driven checks of bypass_ctrl forwarding selects,
//             load-use stall, flush/hold handling, async reset and counter
//             saturation (second instance with CNT_W=4, no MEM load forward).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bypass_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_rs_used;
  logic        id_rt_used;
  logic        id_wr_en;
  logic [4:0]  id_rd;
  logic        id_is_load;
  logic        hold;
  logic        flush;

  logic [3:0]  sel_rs0, sel_rt0, sel_rs1, sel_rt1;
  logic        stall0, stall1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  int n_chk  = 0;
  int n_fail = 0;

  bypass_ctrl #(.REG_AW(5), .LOAD_MEM_FWD(1'b1), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
    .id_rd(id_rd), .id_is_load(id_is_load), .hold(hold), .flush(flush),
    .sel_rs(sel_rs0), .sel_rt(sel_rt0), .stall(stall0), .stall_cnt(cnt0)
  );

  bypass_ctrl #(.REG_AW(5), .LOAD_MEM_FWD(1'b0), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
    .id_rd(id_rd), .id_is_load(id_is_load), .hold(hold), .flush(flush),
    .sel_rs(sel_rs1), .sel_rt(sel_rt1), .stall(stall1), .stall_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        rsu;
    logic        rtu;
    logic        wr;
    logic [4:0]  rd;
    logic        ld;
    logic        hold;
    logic        flush;
    logic [3:0]  e_rs;
    logic [3:0]  e_rt;
    logic        e_stall;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic rsu, input logic rtu, input logic wr,
                              input logic [4:0] rd, input logic ld, input logic hl,
                              input logic fl, input logic [3:0] ers, input logic [3:0] ert,
                              input logic est, input logic [15:0] ecnt);
    vec_t x;
    x.v = v; x.rs = rs; x.rt = rt; x.rsu = rsu; x.rtu = rtu; x.wr = wr; x.rd = rd;
    x.ld = ld; x.hold = hl; x.flush = fl; x.e_rs = ers; x.e_rt = ert;
    x.e_stall = est; x.e_cnt = ecnt;
    return x;
  endfunction

  task automatic apply(input vec_t x);
    id_valid = x.v; id_rs = x.rs; id_rt = x.rt; id_rs_used = x.rsu; id_rt_used = x.rtu;
    id_wr_en = x.wr; id_rd = x.rd; id_is_load = x.ld; hold = x.hold; flush = x.flush;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Step to the next drive point (just after the rising edge)
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                v  rs  rt  rsu rtu wr rd  ld hl fl  e_rs     e_rt     st cnt
    vecs[0]  = mk(1, 1,  2,  1, 1, 1, 3,  0, 0, 0, 4'b0001, 4'b0001, 0, 0); // add r3
    vecs[1]  = mk(1, 3,  3,  1, 1, 1, 4,  0, 0, 0, 4'b0010, 4'b0010, 0, 0); // sub r4,r3,r3
    vecs[2]  = mk(1, 3,  6,  1, 1, 1, 5,  0, 0, 0, 4'b0100, 4'b0001, 0, 0); // r3 from MEM
    vecs[3]  = mk(1, 3,  0,  1, 1, 1, 10, 0, 0, 0, 4'b1000, 4'b0001, 0, 0); // r3 from WB, rt=r0
    vecs[4]  = mk(1, 3,  4,  1, 1, 1, 0,  0, 0, 0, 4'b0001, 4'b1000, 0, 0); // r3 gone; write r0
    vecs[5]  = mk(1, 0,  10, 1, 0, 1, 7,  1, 0, 0, 4'b0001, 4'b0001, 0, 0); // read r0, r0 in EX; lw r7
    vecs[6]  = mk(1, 7,  2,  1, 1, 1, 8,  0, 0, 0, 4'b0010, 4'b0001, 1, 0); // load-use stall
    vecs[7]  = mk(1, 7,  2,  1, 1, 1, 8,  0, 0, 0, 4'b0100, 4'b0001, 0, 1); // forwarded from MEM
    vecs[8]  = mk(1, 8,  7,  1, 1, 1, 9,  0, 0, 0, 4'b0010, 4'b1000, 0, 1); // write r9 #1
    vecs[9]  = mk(1, 9,  8,  1, 1, 1, 9,  0, 0, 0, 4'b0010, 4'b0100, 0, 1); // write r9 #2
    vecs[10] = mk(1, 9,  9,  1, 0, 1, 9,  0, 0, 0, 4'b0010, 4'b0001, 0, 1); // write r9 #3, rt unused
    vecs[11] = mk(1, 9,  9,  1, 1, 0, 9,  0, 0, 0, 4'b0010, 4'b0010, 0, 1); // r9 in EX/MEM/WB
    vecs[12] = mk(0, 9,  9,  1, 1, 0, 9,  0, 0, 0, 4'b0100, 4'b0100, 0, 1); // EX non-writer skipped
    vecs[13] = mk(1, 9,  9,  1, 1, 1, 11, 1, 0, 0, 4'b1000, 4'b1000, 0, 1); // lw r11
    vecs[14] = mk(1, 11, 0,  1, 0, 1, 12, 0, 0, 1, 4'b0010, 4'b0001, 0, 1); // flush beats stall
    vecs[15] = mk(1, 11, 0,  1, 0, 1, 13, 1, 0, 0, 4'b0100, 4'b0001, 0, 1); // EX was bubble; lw r13
    vecs[16] = mk(1, 13, 11, 1, 1, 1, 14, 0, 1, 0, 4'b0010, 4'b1000, 1, 1); // hold 1
    vecs[17] = mk(1, 13, 11, 1, 1, 1, 14, 0, 1, 0, 4'b0010, 4'b1000, 1, 1); // hold 2
    vecs[18] = mk(1, 13, 11, 1, 1, 1, 14, 0, 1, 0, 4'b0010, 4'b1000, 1, 1); // hold 3
    vecs[19] = mk(1, 13, 11, 1, 1, 1, 14, 0, 0, 0, 4'b0010, 4'b1000, 1, 1); // release hold
    vecs[20] = mk(1, 13, 11, 1, 1, 1, 14, 0, 0, 0, 4'b0100, 4'b0001, 0, 2); // after stall

    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    #3;
    chk("reset sel_rs", {28'd0, sel_rs0}, 32'h1);
    chk("reset sel_rt", {28'd0, sel_rt0}, 32'h1);
    chk("reset stall",  {31'd0, stall0},  32'h0);
    chk("reset cnt",    {16'd0, cnt0},    32'h0);
    chk("reset dut1 sel_rs", {28'd0, sel_rs1}, 32'h1);
    chk("reset dut1 cnt",    {28'd0, cnt1},    32'h0);
    step();
    step();
    rst_n = 1'b1;

    // Table-driven main sequence, one row per cycle
    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d sel_rs", i), {28'd0, sel_rs0}, {28'd0, vecs[i].e_rs});
      chk($sformatf("vec%0d sel_rt", i), {28'd0, sel_rt0}, {28'd0, vecs[i].e_rt});
      chk($sformatf("vec%0d stall", i),  {31'd0, stall0},  {31'd0, vecs[i].e_stall});
      chk($sformatf("vec%0d cnt", i),    {16'd0, cnt0},    {16'd0, vecs[i].e_cnt});
      step();
    end

    // Async reset mid-cycle with a load to r5 sitting in EX
    apply(mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0));
    step();
    apply(mk(1, 5, 5, 1, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("pre-reset sel_rs", {28'd0, sel_rs0}, 32'h2);
    chk("pre-reset stall",  {31'd0, stall0},  32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async reset sel_rs", {28'd0, sel_rs0}, 32'h1);
    chk("async reset sel_rt", {28'd0, sel_rt0}, 32'h1);
    chk("async reset stall",  {31'd0, stall0},  32'h0);
    chk("async reset cnt",    {16'd0, cnt0},    32'h0);
    step();
    rst_n = 1'b1;

    // Repeated load-use pairs: dut1 stalls two cycles each, saturating its 4-bit counter
    for (int it = 0; it < 10; it++) begin
      apply(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
      step();
      apply(mk(1, 1, 0, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      chk($sformatf("sat%0d dut1 stall EX", it), {31'd0, stall1}, 32'h1);
      if (it == 0) chk("fwd dut0 stall EX", {31'd0, stall0}, 32'h1);
      step();
      @(negedge clk);
      chk($sformatf("sat%0d dut1 stall MEM", it), {31'd0, stall1}, 32'h1);
      if (it == 0) begin
        chk("fwd dut0 stall MEM", {31'd0, stall0}, 32'h0);
        chk("fwd dut0 sel_rs MEM", {28'd0, sel_rs0}, 32'h4);
        chk("nofwd dut1 sel_rs MEM", {28'd0, sel_rs1}, 32'h4);
      end
      step();
      if (it == 0) begin
        chk("dut1 cnt after one pair", {28'd0, cnt1}, 32'h2);
        chk("dut0 cnt after one pair", {16'd0, cnt0}, 32'h1);
      end
      if (it == 6) chk("dut1 cnt at 14", {28'd0, cnt1}, 32'hE);
    end
    chk("dut1 cnt saturated", {28'd0, cnt1}, 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
